multiply_iter: RTL and testbench

- Iterative, parametrised-width integer multiplier for the execute stage.
- Covers all four RISC-V M-extension multiply forms (MUL, MULH, MULHSU, MULHU) through per-operand signedness and a high/low half select.
- Trades area for latency: it retires R multiplier bits per cycle.
- Uses a stb/ack handshake with busy and kill, so the pipeline can stall on it or squash it.

---
 rtl/multiply_iter_if.sv | 40 ++++
 rtl/multiply_iter.sv | 157 +++++++++++++++
 tb/tb_multiply_iter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiply_iter_if.sv
// ---------------------------------------------------------------------------
// multiply_iter_if
// Request/response bundle for the iterative multiplier.
//   master : requester side (drives operands, stb, kill; sees busy/ack/o)
//   slave  : multiplier side
// Signals:
//   a, b         operands, sampled by the multiplier on its accept edge
//   a_signed     a is two's complement
//   b_signed     b is two's complement
//   hi           select upper (1) or lower (0) half of the 2W-bit product
//   stb          request, accepted only while the unit is not busy
//   kill         squash the operation in flight (no ack follows)
//   busy         operation in flight
//   ack          one-cycle result pulse
//   o            selected result half, held until the next ack
// ---------------------------------------------------------------------------
interface multiply_iter_if #(
    parameter int W = 32
);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         a_signed;
    logic         b_signed;
    logic         hi;
    logic         stb;
    logic         kill;
    logic         busy;
    logic         ack;
    logic [W-1:0] o;

    modport master (
        output a, b, a_signed, b_signed, hi, stb, kill,
        input  busy, ack, o
    );

    modport slave (
        input  a, b, a_signed, b_signed, hi, stb, kill,
        output busy, ack, o
    );
endinterface

// File: rtl/multiply_iter.sv
// ---------------------------------------------------------------------------
// multiply_iter
// Iterative W x W -> 2W integer multiplier covering MUL / MULH / MULHSU /
// MULHU. Operands are reduced to unsigned magnitudes on accept, R multiplier
// bits are retired per cycle into a 2W-bit accumulator, and the sign is
// re-applied on the final iteration before the requested half is registered.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   multiply_iter_if.slave (operands, stb/kill in; busy/ack/o out)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for stb; busy=0, ack=0
// RUN   | retiring R multiplier bits per edge; busy=1
// DONE  | result cycle; ack=1, o valid; a new stb is accepted here
// ---------------------------------------------------------------------------
module multiply_iter #(
    parameter int W = 32,
    parameter int R = 4
) (
    input  logic                clk,
    input  logic                rst,
    multiply_iter_if.slave      bus
);

    localparam int N  = W / R;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    generate
        if (W < 2 || R < 1 || R > W || (W % R) != 0) begin : g_bad_params
            $error("multiply_iter: need W >= 2, 1 <= R <= W and W %% R == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic            neg;
    logic            hi_q;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic            busy_q;
    logic            ack_q;
    logic [W-1:0]    o_q;

    // Operand conditioning on the request side.
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;

    // Iteration datapath.
    logic [R-1:0]    digit;
    logic [2*W-1:0]  partial;
    logic [2*W-1:0]  acc_next;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    mag_b_shr;
    logic            last;
    logic            accept;

    always_comb begin
        a_neg = bus.a_signed & bus.a[W-1];
        b_neg = bus.b_signed & bus.b[W-1];
        // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
    end

    always_comb begin
        digit    = mag_b[R-1:0];
        partial  = ({{W{1'b0}}, mag_a} * {{(2*W-R){1'b0}}, digit}) << (R * int'(cnt));
        acc_next = acc + partial;
        prod     = neg ? -acc_next : acc_next;
        last     = (cnt == CNT_LAST);
        accept   = bus.stb & ~bus.kill;
    end

    // Consumed multiplier bits are shifted out; with R == W everything goes.
    generate
        if (R < W) begin : g_shr
            assign mag_b_shr = {{R{1'b0}}, mag_b[W-1:R]};
        end else begin : g_shr_all
            assign mag_b_shr = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mag_a  <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            hi_q   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
            o_q    <= '0;
        end else if (bus.kill) begin
            // Kill beats everything, including a pending completion or accept.
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    ack_q <= 1'b0;
                    if (accept) begin
                        mag_a  <= a_mag;
                        mag_b  <= b_mag;
                        neg    <= a_neg ^ b_neg;
                        hi_q   <= bus.hi;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    mag_b <= mag_b_shr;
                    if (last) begin
                        cnt    <= '0;
                        o_q    <= hi_q ? prod[2*W-1:W] : prod[W-1:0];
                        busy_q <= 1'b0;
                        ack_q  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    ack_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.ack  = ack_q;
    assign bus.o    = o_q;

endmodule

// File: tb/tb_multiply_iter.sv
// ---------------------------------------------------------------------------
// tb_multiply_iter
// Directed handshake/sign tests on a W=32, R=4 instance plus a randomized
// sweep driving R=1/4/8/32 instances in lockstep against a 64-bit model.
// ---------------------------------------------------------------------------
module tb_multiply_iter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    multiply_iter_if #(.W(32)) u_if  ();
    multiply_iter_if #(.W(32)) if1   ();
    multiply_iter_if #(.W(32)) if8   ();
    multiply_iter_if #(.W(32)) if32  ();

    multiply_iter #(.W(32), .R(4))  dut_r4  (.clk(clk), .rst(rst), .bus(u_if));
    multiply_iter #(.W(32), .R(1))  dut_r1  (.clk(clk), .rst(rst), .bus(if1));
    multiply_iter #(.W(32), .R(8))  dut_r8  (.clk(clk), .rst(rst), .bus(if8));
    multiply_iter #(.W(32), .R(32)) dut_r32 (.clk(clk), .rst(rst), .bus(if32));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact product of the two operands as integers, half selected.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic as, input logic bs, input logic hi);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = as ? {{32{a[31]}}, a} : {32'h0, a};
        eb = bs ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return hi ? p[63:32] : p[31:0];
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic as,
                         input logic bs, input logic hi, input logic stb);
        u_if.a = a; u_if.b = b; u_if.a_signed = as; u_if.b_signed = bs;
        u_if.hi = hi; u_if.stb = stb;
    endtask

    task automatic drive_all(input logic [31:0] a, input logic [31:0] b, input logic as,
                             input logic bs, input logic hi, input logic stb);
        drive(a, b, as, bs, hi, stb);
        if1.a = a;  if1.b = b;  if1.a_signed = as;  if1.b_signed = bs;  if1.hi = hi;  if1.stb = stb;
        if8.a = a;  if8.b = b;  if8.a_signed = as;  if8.b_signed = bs;  if8.hi = hi;  if8.stb = stb;
        if32.a = a; if32.b = b; if32.a_signed = as; if32.b_signed = bs; if32.hi = hi; if32.stb = stb;
    endtask

    task automatic scramble();
        u_if.a = $urandom; u_if.b = $urandom;
        u_if.a_signed = 1'($urandom); u_if.b_signed = 1'($urandom); u_if.hi = 1'($urandom);
    endtask

    // Counts acks over a window; used where no ack may appear.
    task automatic expect_no_ack(input int cycles, input string name);
        int acks;
        acks = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (u_if.ack === 1'b1) acks++;
        end
        n_cmp++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL %s: got %0d acks, want 0", name, acks);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic as,
                          input logic bs, input logic hi, input logic [31:0] exp,
                          input string name);
        int t;
        int busy_cycles;
        bit seen;
        drive(a, b, as, bs, hi, 1'b1);
        tick();
        u_if.stb = 1'b0;
        scramble();
        t = 0; busy_cycles = 0; seen = 0;
        while (!seen && t <= 20) begin
            if (u_if.ack === 1'b1) seen = 1;
            else begin
                if (u_if.busy === 1'b1) busy_cycles++;
                tick();
                t++;
            end
        end
        n_cmp++;
        if (!seen || t != 8) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges (seen=%0d), want 8", name, t, seen);
        end
        n_cmp++;
        if (u_if.o !== exp) begin
            n_err++;
            $display("FAIL %s result: got %h, want %h", name, u_if.o, exp);
        end
        n_cmp++;
        if (busy_cycles != 8 || u_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy: got %0d cycles (busy at ack=%b), want 8 and 0",
                     name, busy_cycles, u_if.busy);
        end
        tick();
        n_cmp++;
        if (u_if.ack !== 1'b0) begin
            n_err++;
            $display("FAIL %s ack width: got ack=%b one cycle later, want 0", name, u_if.ack);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if (u_if.busy !== 1'b0 || u_if.ack !== 1'b0 || u_if.o !== 32'h0) begin
            n_err++;
            $display("FAIL reset: got busy=%b ack=%b o=%h, want 0 0 0", u_if.busy, u_if.ack, u_if.o);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (u_if.busy !== 1'b0 || u_if.ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b ack=%b, want 0 0", u_if.busy, u_if.ack);
        end
    endtask

    task automatic test_forms();
        run_op(32'd7,        32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFEB, "mul");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, "mulhu_hi");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0001, "mulhu_lo");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, "mulhsu_hi");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0001, "mulhsu_lo");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h4000_0000, "mulh");
    endtask

    task automatic test_kill();
        drive(32'd123, 32'd456, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        u_if.stb = 1'b0;
        tick(); tick();
        u_if.kill = 1'b1;
        tick();
        u_if.kill = 1'b0;
        n_cmp++;
        if (u_if.busy !== 1'b0 || u_if.ack !== 1'b0 || u_if.o !== 32'h4000_0000) begin
            n_err++;
            $display("FAIL kill_abort: got busy=%b ack=%b o=%h, want 0 0 40000000",
                     u_if.busy, u_if.ack, u_if.o);
        end
        expect_no_ack(15, "kill_no_ack");
        run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd15, "after_kill");
        // kill together with stb while idle: nothing accepted
        drive(32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        u_if.kill = 1'b1;
        tick();
        u_if.kill = 1'b0;
        u_if.stb  = 1'b0;
        n_cmp++;
        if (u_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL kill_with_stb: got busy=%b, want 0", u_if.busy);
        end
        expect_no_ack(12, "kill_with_stb_no_ack");
    endtask

    task automatic test_kill_in_done();
        int t;
        drive(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        u_if.stb = 1'b0;
        t = 0;
        while (u_if.ack !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        n_cmp++;
        if (u_if.ack !== 1'b1 || u_if.o !== 32'd6) begin
            n_err++;
            $display("FAIL kill_in_done ack: got ack=%b o=%h, want 1 00000006", u_if.ack, u_if.o);
        end
        drive(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        u_if.kill = 1'b1;
        tick();
        u_if.kill = 1'b0;
        u_if.stb  = 1'b0;
        n_cmp++;
        if (u_if.busy !== 1'b0 || u_if.ack !== 1'b0 || u_if.o !== 32'd6) begin
            n_err++;
            $display("FAIL kill_in_done state: got busy=%b ack=%b o=%h, want 0 0 00000006",
                     u_if.busy, u_if.ack, u_if.o);
        end
        expect_no_ack(12, "kill_in_done_no_ack");
    endtask

    task automatic test_stb_while_busy();
        int acks;
        logic [31:0] got;
        drive(32'd1000, 32'd2000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        u_if.stb = 1'b0;
        tick(); tick(); tick();
        drive(32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        u_if.stb = 1'b0;
        acks = 0; got = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (u_if.ack === 1'b1) begin
                acks++;
                got = u_if.o;
            end
        end
        n_cmp++;
        if (acks != 1 || got !== 32'd2000000) begin
            n_err++;
            $display("FAIL stb_while_busy: got %0d acks o=%h, want 1 ack o=%h", acks, got, 32'd2000000);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa [64];
        logic [31:0] qb [64];
        logic        qas[64];
        logic        qbs[64];
        logic        qhi[64];
        logic [31:0] exp;
        int          acks;
        acks = 0;
        for (int e = 0; e < 45; e++) begin
            qa[e] = $urandom; qb[e] = $urandom;
            qas[e] = 1'($urandom); qbs[e] = 1'($urandom); qhi[e] = 1'($urandom);
            drive(qa[e], qb[e], qas[e], qbs[e], qhi[e], 1'b1);
            tick();
            if (u_if.ack === 1'b1) begin
                n_cmp++;
                if (e != 8 + 9 * acks || e < 8) begin
                    n_err++;
                    $display("FAIL b2b spacing: ack at edge %0d, want %0d", e, 8 + 9 * acks);
                end else begin
                    exp = ref_mul(qa[e-8], qb[e-8], qas[e-8], qbs[e-8], qhi[e-8]);
                    n_cmp++;
                    if (u_if.o !== exp) begin
                        n_err++;
                        $display("FAIL b2b result %0d: got %h, want %h", acks, u_if.o, exp);
                    end
                end
                acks++;
            end
        end
        u_if.stb = 1'b0;
        n_cmp++;
        if (acks != 5) begin
            n_err++;
            $display("FAIL b2b count: got %0d acks, want 5", acks);
        end
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_rst_mid_op();
        drive(32'd77, 32'd88, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        u_if.stb = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (u_if.busy !== 1'b0 || u_if.ack !== 1'b0 || u_if.o !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_op: got busy=%b ack=%b o=%h, want 0 0 0", u_if.busy, u_if.ack, u_if.o);
        end
        expect_no_ack(12, "rst_mid_op_no_ack");
    endtask

    task automatic test_random_sweep(input int ops);
        int          lat_exp[4];
        int          lat[4];
        bit          seen[4];
        logic [31:0] res[4];
        logic [3:0]  acks;
        logic [31:0] outs[4];
        logic [31:0] a, b, exp;
        logic        as, bs, hi;
        int          t;
        lat_exp[0] = 8; lat_exp[1] = 32; lat_exp[2] = 4; lat_exp[3] = 1;
        for (int k = 0; k < ops; k++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h8000_0000;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            as = 1'($urandom); bs = 1'($urandom); hi = 1'($urandom);
            exp = ref_mul(a, b, as, bs, hi);
            drive_all(a, b, as, bs, hi, 1'b1);
            tick();
            drive_all($urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                seen[i] = 0; lat[i] = -1; res[i] = '0;
            end
            t = 0;
            while (!(seen[0] && seen[1] && seen[2] && seen[3]) && t <= 40) begin
                acks = {if32.ack, if8.ack, if1.ack, u_if.ack};
                outs[0] = u_if.o; outs[1] = if1.o; outs[2] = if8.o; outs[3] = if32.o;
                for (int i = 0; i < 4; i++) begin
                    if (acks[i] === 1'b1 && !seen[i]) begin
                        seen[i] = 1; lat[i] = t; res[i] = outs[i];
                    end
                end
                if (!(seen[0] && seen[1] && seen[2] && seen[3])) begin
                    tick();
                    t++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (!seen[i] || lat[i] != lat_exp[i] || res[i] !== exp) begin
                    n_err++;
                    $display("FAIL sweep op %0d dut %0d: a=%h b=%h as=%b bs=%b hi=%b got o=%h lat=%0d, want o=%h lat=%0d",
                             k, i, a, b, as, bs, hi, res[i], lat[i], exp, lat_exp[i]);
                end
            end
        end
        tick();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_cmp = 0;
        n_err = 0;
        drive_all('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        u_if.kill = 1'b0; if1.kill = 1'b0; if8.kill = 1'b0; if32.kill = 1'b0;
        test_reset();
        test_forms();
        test_kill();
        test_kill_in_done();
        test_stb_while_busy();
        test_back_to_back();
        test_rst_mid_op();
        test_random_sweep(1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
